// File: rtl/pio_stream_sequencer.sv
// HPS-triggered capture of a 256-bit datavalid stream, buffered in a small word FIFO
// and serialized into a 32-bit valid/ready lane stream with a status word for the HPS.
module pio_stream_sequencer #(
    parameter int DATA_W     = 256,
    parameter int LANE_W     = 32,
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       trigger,
    input  logic [31:0]       num_words,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [31:0]       status
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W  = PTR_W + 1;
    localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [FCNT_W-1:0]  FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);
    localparam logic [LANE_IW-1:0] LAST_LANE     = LANE_IW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               trig_q, trig_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   accepted_q, accepted_d;
    logic [CNT_W-1:0]   popped_q, popped_d;
    logic               overflow_q, overflow_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic [LANE_IW-1:0] lane_q, lane_d;
    logic               word_last_q, word_last_d;
    logic [LANE_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [31:0]        status_q, status_d;

    logic               start_pulse;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [LANE_IW-1:0] lane_nxt;
    logic [CNT_W-1:0]   popped_inc;
    logic [CNT_W-1:0]   new_target;
    logic               unused_bits;

    assign unused_bits = ^{trigger[31:2], num_words[31:CNT_W]};

    assign start_pulse = trigger[0] & ~trig_q;
    assign fifo_full   = (count_q == FIFO_FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign lane_nxt    = lane_q + 1'b1;
    assign popped_inc  = popped_q + 1'b1;
    assign new_target  = num_words[CNT_W-1:0];

    always_comb begin
        state_d     = state_q;
        trig_d      = trigger[0];
        target_d    = target_q;
        accepted_d  = accepted_q;
        popped_d    = popped_q;
        overflow_d  = overflow_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        word_d      = word_q;
        lane_d      = lane_q;
        word_last_d = word_last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_pulse) begin
                    target_d   = new_target;
                    accepted_d = '0;
                    popped_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = (new_target != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Full comes from the registered count, so a same-cycle pop never frees a slot.
                if (in_valid) begin
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end else if (accepted_q < target_q) begin
                        push       = 1'b1;
                        accepted_d = accepted_q + 1'b1;
                    end
                end
                if (accepted_d == target_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !out_valid_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!out_valid_q) begin
            pop = !fifo_empty;
        end else if (out_ready) begin
            if (lane_q == LAST_LANE) begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end else begin
                lane_d     = lane_nxt;
                out_data_d = word_q[int'(lane_nxt) * LANE_W +: LANE_W];
                out_last_d = word_last_q && (lane_nxt == LAST_LANE);
            end
        end

        // A popped word is presented immediately on lane 0; out_last tracks the target word.
        if (pop) begin
            word_d      = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + 1'b1;
            lane_d      = '0;
            out_valid_d = 1'b1;
            out_data_d  = word_d[LANE_W-1:0];
            popped_d    = popped_inc;
            word_last_d = (popped_inc == target_q);
            out_last_d  = word_last_d && (LANES == 1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        status_d = {16'(accepted_d), 12'b0, (count_d == FIFO_FULL_CNT), overflow_d,
                    (state_d == DONE), ((state_d == RUN) || (state_d == DRAIN))};
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        // Abort behaves exactly like reset and wins over everything else.
        if (reset || trigger[1]) begin
            state_q     <= IDLE;
            trig_q      <= 1'b0;
            target_q    <= '0;
            accepted_q  <= '0;
            popped_q    <= '0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            word_last_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trig_d;
            target_q    <= target_d;
            accepted_q  <= accepted_d;
            popped_q    <= popped_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            word_q      <= word_d;
            lane_q      <= lane_d;
            word_last_q <= word_last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            status_q    <= status_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign status    = status_q;

endmodule

// File: tb/tb_pio_stream_sequencer.sv
// Scoreboard bench for pio_stream_sequencer: directed captures push expected lanes into
// a queue, and an independent monitor checks every accepted beat against it.
module tb_pio_stream_sequencer;
    logic         clk;
    logic         reset;
    logic [31:0]  trigger;
    logic [31:0]  num_words;
    logic [255:0] in_data;
    logic         in_valid;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [31:0]  status;

    int compared   = 0;
    int mismatched = 0;
    int beats      = 0;

    logic [32:0] exp_q[$];

    logic ready_mode  = 1'b0;
    logic ready_const = 1'b0;

    pio_stream_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .num_words (num_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] mk(input int base);
        logic [255:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*32 +: 32] = 32'(base + i);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one input word for the coming edge and records the lanes it should produce.
    task automatic applyStimulus(input logic [255:0] w, input bit accept, input bit last_word);
        in_data  = w;
        in_valid = 1'b1;
        if (accept) begin
            for (int i = 0; i < 8; i++) begin
                exp_q.push_back({(last_word && i == 7), w[i*32 +: 32]});
            end
        end
    endtask

    task automatic start_capture(input int n);
        trigger = 32'h0;
        tick();
        trigger   = 32'h1;
        num_words = 32'(n);
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (status[1]) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, 64'(seen), 64'd1);
    endtask

    task automatic end_of_test(input string name, input int beat_count);
        checkOutput({name, "_beats"}, 64'(beats), 64'(beat_count));
        checkOutput({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        beats = 0;
    endtask

    // Ready driver: constant level or the repeating 1,0,0,1 pattern.
    initial begin
        logic [3:0] pat;
        int pidx;
        pat       = 4'b1001;
        pidx      = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode) begin
                out_ready = pat[pidx];
                pidx      = (pidx + 1) % 4;
            end else begin
                out_ready = ready_const;
            end
        end
    end

    // Monitor: checks every handshake against the scoreboard and stall stability.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || trigger[1]) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("stall_hold", {31'b0, out_valid, out_last, out_data},
                                {31'b0, 1'b1, prev_last, prev_data});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", {31'b0, out_last, out_data}, 64'hDEAD_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("beat", {31'b0, out_last, out_data}, {31'b0, e});
                        beats++;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        trigger   = 32'h0;
        num_words = 32'h0;
        in_data   = '0;
        in_valid  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_status", 64'(status), 64'h0);
        checkOutput("reset_valid", 64'(out_valid), 64'h0);
        checkOutput("reset_data", 64'(out_data), 64'h0);
        checkOutput("reset_last", 64'(out_last), 64'h0);

        $display("[TB] T1 basic");
        ready_const = 1'b1;
        tick();
        start_capture(2);
        applyStimulus(mk(0), 1'b1, 1'b0);
        tick();
        applyStimulus(mk(8), 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("T1_latency_n", 64'(out_valid), 64'h0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("T1_latency_n1", 64'(out_valid), 64'h1);
        wait_done("T1_done", 100);
        checkOutput("T1_status", 64'(status), 64'h0002_0002);
        end_of_test("T1", 16);

        $display("[TB] T2 backpressure");
        ready_mode = 1'b1;
        tick();
        start_capture(2);
        applyStimulus(mk(0), 1'b1, 1'b0);
        tick();
        applyStimulus(mk(8), 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_done("T2_done", 200);
        checkOutput("T2_status", 64'(status), 64'h0002_0002);
        ready_mode = 1'b0;
        end_of_test("T2", 16);

        $display("[TB] T3 overflow");
        ready_const = 1'b0;
        repeat (3) tick();
        start_capture(8);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(mk(32'h100 + 8 * k), (k < 5), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("T3_status_full", 64'(status), 64'h0005_000D);
        checkOutput("T3_no_beats_yet", 64'(beats), 64'h0);
        ready_const = 1'b1;
        for (int k = 5; k < 8; k++) begin
            bit room;
            room = 1'b0;
            for (int c = 0; c < 200; c++) begin
                tick();
                if (!status[3]) begin
                    room = 1'b1;
                    break;
                end
            end
            checkOutput("T3_room", 64'(room), 64'h1);
            applyStimulus(mk(32'h200 + 8 * k), 1'b1, (k == 7));
            tick();
            in_valid = 1'b0;
        end
        wait_done("T3_done", 300);
        checkOutput("T3_status", 64'(status), 64'h0008_0006);
        end_of_test("T3", 64);

        $display("[TB] T4 zero count");
        tick();
        start_capture(0);
        @(negedge clk);
        checkOutput("T4_status", 64'(status), 64'h0000_0002);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mk(32'h700 + 8 * k), 1'b0, 1'b0);
            tick();
            checkOutput("T4_no_valid", 64'(out_valid), 64'h0);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("T4_status_after", 64'(status), 64'h0000_0002);
        checkOutput("T4_valid_after", 64'(out_valid), 64'h0);
        end_of_test("T4", 0);

        $display("[TB] T5 abort");
        tick();
        start_capture(4);
        applyStimulus(mk(32'h300), 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        trigger  = 32'h3;
        tick();
        @(negedge clk);
        checkOutput("T5_abort_valid", 64'(out_valid), 64'h0);
        checkOutput("T5_abort_status", 64'(status), 64'h0);
        tick();
        start_capture(1);
        applyStimulus(mk(32'h400), 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_done("T5_done", 100);
        checkOutput("T5_status", 64'(status), 64'h0001_0002);
        end_of_test("T5", 8);

        $display("[TB] T6 reset and retrigger");
        ready_const = 1'b0;
        tick();
        start_capture(2);
        applyStimulus(mk(32'h500), 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        trigger  = 32'h0;
        tick();
        trigger   = 32'h1;
        num_words = 32'd7;
        tick();
        @(negedge clk);
        checkOutput("T6_retrigger_ignored", 64'(status), 64'h0001_0001);
        tick();
        applyStimulus(mk(32'h508), 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("T6_drain_status", 64'(status), 64'h0002_0001);
        tick();
        trigger = 32'h0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("T6_reset_valid", 64'(out_valid), 64'h0);
        checkOutput("T6_reset_data", 64'(out_data), 64'h0);
        checkOutput("T6_reset_last", 64'(out_last), 64'h0);
        checkOutput("T6_reset_status", 64'(status), 64'h0);
        ready_const = 1'b1;
        tick();
        start_capture(1);
        applyStimulus(mk(32'h600), 1'b1, 1'b1);
        tick();
        in_valid = 1'b0;
        wait_done("T6_done", 100);
        checkOutput("T6_status", 64'(status), 64'h0001_0002);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("T6_held_start", 64'(status), 64'h0001_0002);
        end_of_test("T6", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
